cordic_rr_scheduler: RTL and testbench

- Shares one fixed-latency pipelined `cordic` core (Q16.16 operands, e.g. 65536 = 1.0, 102943 = pi/2) among NREQ requesters.
- Each cycle, a round-robin arbiter grants at most one valid request. The granted operands are registered and driven into the core.
- A tag shift register, matched to the core latency, routes each result back to its originating requester with a one-cycle valid strobe.
- Sits between the angle/vector producers and the `cordic` instance. The core itself has no valid or handshake signals.

---
 rtl/cordic_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_cordic_rr_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_scheduler.sv
// rtl/cordic_rr_scheduler.sv - round-robin sharing of one fixed-latency pipelined cordic core
// among NREQ requesters, with tag-routed one-cycle result strobes.
module cordic_rr_scheduler #(
  parameter int NREQ         = 4,
  parameter int PIPE_LATENCY = 16,
  parameter int W            = 32,
  parameter int IDW          = 2,
  localparam int CW          = $clog2(PIPE_LATENCY + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x0,
  input  logic [NREQ*W-1:0] req_y0,
  input  logic [NREQ*W-1:0] req_z0,
  output logic [W-1:0]      cordic_x0,
  output logic [W-1:0]      cordic_y0,
  output logic [W-1:0]      cordic_z0,
  input  logic [W-1:0]      cordic_x,
  input  logic [W-1:0]      cordic_y,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_x,
  output logic [W-1:0]      rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic [CW-1:0]     inflight,
  output logic              idle
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gid;
  logic           found;
  logic [IDW:0]   cand;
  logic [IDW:0]   nxt;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        gid   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found) req_ready[gid] = 1'b1;
  end

  always_comb begin
    nxt = {1'b0, gid} + (IDW+1)'(1);
    if (nxt >= NREQ_W) nxt = '0;
  end

  // Issue-stage tag travels alongside the registered core operands.
  logic           iss_v;
  logic [IDW-1:0] iss_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cordic_x0 <= '0;
      cordic_y0 <= '0;
      cordic_z0 <= '0;
      iss_v     <= 1'b0;
      iss_id    <= '0;
    end else begin
      iss_v <= found;
      if (found) begin
        ptr       <= nxt[IDW-1:0];
        cordic_x0 <= req_x0[int'(gid)*W +: W];
        cordic_y0 <= req_y0[int'(gid)*W +: W];
        cordic_z0 <= req_z0[int'(gid)*W +: W];
        iss_id    <= gid;
      end
    end
  end

  // One tag stage per core pipeline stage; the core never stalls, so neither does this.
  logic [PIPE_LATENCY-1:0] tag_v;
  logic [IDW-1:0]          tag_id [PIPE_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k < PIPE_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[PIPE_LATENCY-2:0], iss_v};
      tag_id[0] <= iss_id;
      for (int k = 1; k < PIPE_LATENCY; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  logic            rsp_fire;
  logic [NREQ-1:0] rsp_oh;

  assign rsp_fire = tag_v[PIPE_LATENCY-1];

  always_comb begin
    rsp_oh = '0;
    rsp_oh[tag_id[PIPE_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= rsp_fire ? rsp_oh : '0;
      if (rsp_fire) begin
        rsp_x  <= cordic_x;
        rsp_y  <= cordic_y;
        rsp_id <= tag_id[PIPE_LATENCY-1];
      end
    end
  end

  // Bounded by PIPE_LATENCY+1 because the pipeline holds at most that many tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({found, rsp_fire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign idle = (inflight == '0) && (req_valid == '0);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// tb/tb_cordic_rr_scheduler.sv - directed vector bench for cordic_rr_scheduler with a
// latency-16 core stub (x = x0+1, y = z0).
module tb_cordic_rr_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 16;
  localparam int W    = 32;
  localparam int SZ   = 512;
  localparam int RSP_SAMPLES = 18;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x0, req_y0, req_z0;
  logic [W-1:0]      cordic_x0, cordic_y0, cordic_z0;
  logic [W-1:0]      cordic_x, cordic_y;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_x, rsp_y;
  logic [1:0]        rsp_id;
  logic [4:0]        inflight;
  logic              idle;

  cordic_rr_scheduler #(.NREQ(NREQ), .PIPE_LATENCY(LAT), .W(W), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_z0(req_z0),
    .cordic_x0(cordic_x0), .cordic_y0(cordic_y0), .cordic_z0(cordic_z0),
    .cordic_x(cordic_x), .cordic_y(cordic_y),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Core stub: 16 register stages, no reset, no handshake.
  logic [W-1:0] sx [LAT];
  logic [W-1:0] sy [LAT];
  always @(posedge clk) begin
    sx[0] <= cordic_x0 + 32'd1;
    sy[0] <= cordic_z0;
    for (int k = 1; k < LAT; k++) begin
      sx[k] <= sx[k-1];
      sy[k] <= sy[k-1];
    end
  end
  assign cordic_x = sx[LAT-1];
  assign cordic_y = sy[LAT-1];

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] xop [NREQ];
  logic [31:0] zop [NREQ];
  logic [3:0]  exp_rv  [SZ];
  logic [31:0] exp_rx  [SZ];
  logic [31:0] exp_ry  [SZ];
  logic [31:0] exp_rid [SZ];
  int          m, inf, pend_acc, peak, rsp2_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at sample %0d: got %0d expected %0d", name, m, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x0[i*W +: W] = xop[i];
      req_y0[i*W +: W] = 32'(i * 7);
      req_z0[i*W +: W] = zop[i];
    end
  endtask

  // Entered just after a falling edge; leaves after the next falling edge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] er);
    int g;
    req_valid = v;
    #1;
    inf = inf + pend_acc - ((exp_rv[m] != 4'b0) ? 1 : 0);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv[m]));
    if (exp_rv[m] != 4'b0) begin
      chk("rsp_x", rsp_x, exp_rx[m]);
      chk("rsp_y", rsp_y, exp_ry[m]);
      chk("rsp_id", 32'(rsp_id), exp_rid[m]);
    end
    chk("inflight", 32'(inflight), 32'(inf));
    chk("idle", 32'(idle), 32'((inf == 0) && (v == 4'b0)));
    if (int'(inflight) > peak) peak = int'(inflight);
    if (rsp_valid == 4'b0100) rsp2_cnt++;
    pend_acc = (er != 4'b0) ? 1 : 0;
    if (er != 4'b0) begin
      g = oh2i(er);
      exp_rv[m+RSP_SAMPLES]  = er;
      exp_rx[m+RSP_SAMPLES]  = xop[g] + 32'd1;
      exp_ry[m+RSP_SAMPLES]  = zop[g];
      exp_rid[m+RSP_SAMPLES] = 32'(g);
    end
    m++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000, 4'b0000);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst cordic_x0", cordic_x0, 32'd0);
    chk("rst cordic_y0", cordic_y0, 32'd0);
    chk("rst cordic_z0", cordic_z0, 32'd0);
    chk("rst rsp_x", rsp_x, 32'd0);
    chk("rst rsp_y", rsp_y, 32'd0);
    chk("rst rsp_id", 32'(rsp_id), 32'd0);
    chk("rst inflight", 32'(inflight), 32'd0);
    chk("rst idle", 32'(idle), 32'd1);
    for (int i = m; i < SZ; i++) exp_rv[i] = 4'b0;
    inf = 0;
    pend_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m++;
  endtask

  initial begin
    // Four requesters continuously valid, then requesters 1 and 3 only.
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0100};
    vecs[7]  = '{4'b1111, 4'b1000};
    vecs[8]  = '{4'b1010, 4'b0010};
    vecs[9]  = '{4'b1010, 4'b1000};
    vecs[10] = '{4'b1010, 4'b0010};
    vecs[11] = '{4'b1010, 4'b1000};
    vecs[12] = '{4'b1010, 4'b0010};
    vecs[13] = '{4'b1010, 4'b1000};

    for (int i = 0; i < SZ; i++) begin
      exp_rv[i] = 4'b0; exp_rx[i] = '0; exp_ry[i] = '0; exp_rid[i] = '0;
    end
    m = 0; inf = 0; pend_acc = 0; peak = 0; rsp2_cnt = 0;
    rst_n = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      xop[i] = 32'(65536 * (i + 1));
      zop[i] = 32'(1000 + i);
    end
    zop[0] = 32'd102943;
    set_ops();
    @(negedge clk);
    do_reset();

    // Single request from requester 0.
    cycle(4'b0001, 4'b0001);
    drain(20);

    do_reset();
    zop[0] = 32'd1000;
    set_ops();
    peak = 0;
    for (int i = 0; i < 8; i++) cycle(vecs[i].valid, vecs[i].ready);
    drain(20);
    chk("peak inflight 8", 32'(peak), 32'd8);

    for (int i = 8; i < 14; i++) cycle(vecs[i].valid, vecs[i].ready);
    drain(20);

    // Requester 2 alone, back-to-back for 40 cycles.
    peak = 0;
    rsp2_cnt = 0;
    for (int i = 0; i < 40; i++) cycle(4'b0100, 4'b0100);
    drain(20);
    chk("peak inflight 17", 32'(peak), 32'd17);
    chk("req2 responses", 32'(rsp2_cnt), 32'd40);

    // Reset in the middle of traffic discards all outstanding tags.
    for (int i = 0; i < 5; i++) cycle(4'b0001, 4'b0001);
    cycle(4'b0000, 4'b0000);
    do_reset();
    drain(20);
    cycle(4'b1000, 4'b1000);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
